// File: rtl/wordline_predecode_pkg.sv
// Shared constants, the predecode bundle type and the 2-bit group decoder
// used by wordline_predecode_64 and predecode_port.
package wordline_predecode_pkg;

    localparam int unsigned WL_ADDR_W = 6;
    localparam int unsigned GRP_A0_W  = 2;
    localparam int unsigned GRP_A12_W = 4;
    localparam int unsigned GRP_A3_W  = 2;
    localparam int unsigned GRP_A45_W = 4;

    typedef struct packed {
        logic c_na0;
        logic c_a0;
        logic na1_na2;
        logic na1_a2;
        logic a1_na2;
        logic a1_a2;
        logic na3;
        logic a3;
        logic na4_na5;
        logic na4_a5;
        logic a4_na5;
        logic a4_a5;
    } predecode_t;

    // Bit 0 of the result is the both-low line, bit 3 the both-high line.
    function automatic logic [GRP_A12_W-1:0] dec2(input logic [1:0] sel);
        dec2 = 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/predecode_port.sv
// One access port: valid flop, held address register and the 12-line predecode.
// Optional even-parity check on the address under PREDECODE_PARITY_EN.
module predecode_port
    import wordline_predecode_pkg::*;
#(
    parameter int unsigned GateAll = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [0:WL_ADDR_W-1] addr_i,
`ifdef PREDECODE_PARITY_EN
    input  logic                 par_i,
    input  logic                 err_clr_i,
    output logic                 par_err_o,
`endif
    output logic                 acc_ok_o,
    output predecode_t           pd_o
);

    logic                 v_q, v_d;
    logic [0:WL_ADDR_W-1] a_q, a_d;
    logic                 acc_ok;

`ifdef PREDECODE_PARITY_EN
    logic par_bad;
    logic err_q, err_d;

    assign par_bad   = en_i & (^{addr_i, par_i});
    assign acc_ok    = en_i & ~par_bad;
    assign par_err_o = err_q;

    // A new error wins over a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (par_bad) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end
`else
    assign acc_ok = en_i;
`endif

    assign acc_ok_o = acc_ok;

    always_comb begin
        v_d = acc_ok;
        a_d = en_i ? addr_i : a_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q   <= 1'b0;
            a_q   <= '0;
`ifdef PREDECODE_PARITY_EN
            err_q <= 1'b0;
`endif
        end else begin
            v_q   <= v_d;
            a_q   <= a_d;
`ifdef PREDECODE_PARITY_EN
            err_q <= err_d;
`endif
        end
    end

    logic                 grp_en;
    logic [GRP_A12_W-1:0] g12;
    logic [GRP_A3_W-1:0]  g3;
    logic [GRP_A45_W-1:0] g45;

    always_comb begin
        grp_en = (GateAll != 0) ? v_q : 1'b1;
        g12    = dec2(a_q[1:2]) & {GRP_A12_W{grp_en}};
        g3     = {a_q[3], ~a_q[3]} & {GRP_A3_W{grp_en}};
        g45    = dec2(a_q[4:5]) & {GRP_A45_W{grp_en}};

        pd_o         = '0;
        pd_o.c_na0   = v_q & ~a_q[0];
        pd_o.c_a0    = v_q & a_q[0];
        pd_o.na1_na2 = g12[0];
        pd_o.na1_a2  = g12[1];
        pd_o.a1_na2  = g12[2];
        pd_o.a1_a2   = g12[3];
        pd_o.na3     = g3[0];
        pd_o.a3      = g3[1];
        pd_o.na4_na5 = g45[0];
        pd_o.na4_a5  = g45[1];
        pd_o.a4_na5  = g45[2];
        pd_o.a4_a5   = g45[3];
    end

endmodule

// File: rtl/wordline_predecode_64.sv
// Three-port registered wordline predecoder with rd/wr collision flags.
// Optional address parity checking is enabled by defining PREDECODE_PARITY_EN.
module wordline_predecode_64
    import wordline_predecode_pkg::*;
#(
    parameter int unsigned GATE_ALL = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd0_enable,
    input  logic                 rd1_enable,
    input  logic                 wr0_enable,
    input  logic [0:WL_ADDR_W-1] rd0_addr,
    input  logic [0:WL_ADDR_W-1] rd1_addr,
    input  logic [0:WL_ADDR_W-1] wr0_addr,
`ifdef PREDECODE_PARITY_EN
    input  logic                 rd0_addr_par,
    input  logic                 rd1_addr_par,
    input  logic                 wr0_addr_par,
    input  logic                 err_clr,
    output logic                 rd0_par_err,
    output logic                 rd1_par_err,
    output logic                 wr0_par_err,
`endif
    output logic rd0_c_na0, rd0_c_a0,
    output logic rd0_na1_na2, rd0_na1_a2, rd0_a1_na2, rd0_a1_a2,
    output logic rd0_na3, rd0_a3,
    output logic rd0_na4_na5, rd0_na4_a5, rd0_a4_na5, rd0_a4_a5,
    output logic rd1_c_na0, rd1_c_a0,
    output logic rd1_na1_na2, rd1_na1_a2, rd1_a1_na2, rd1_a1_a2,
    output logic rd1_na3, rd1_a3,
    output logic rd1_na4_na5, rd1_na4_a5, rd1_a4_na5, rd1_a4_a5,
    output logic wr0_c_na0, wr0_c_a0,
    output logic wr0_na1_na2, wr0_na1_a2, wr0_a1_na2, wr0_a1_a2,
    output logic wr0_na3, wr0_a3,
    output logic wr0_na4_na5, wr0_na4_a5, wr0_a4_na5, wr0_a4_a5,
    output logic rd0_wr0_hit,
    output logic rd1_wr0_hit
);

    predecode_t rd0_pd, rd1_pd, wr0_pd;
    logic       rd0_ok, rd1_ok, wr0_ok;

    predecode_port #(.GateAll(GATE_ALL)) u_rd0 (
        .clk_i     (clk),
        .rst_i     (reset),
        .en_i      (rd0_enable),
        .addr_i    (rd0_addr),
`ifdef PREDECODE_PARITY_EN
        .par_i     (rd0_addr_par),
        .err_clr_i (err_clr),
        .par_err_o (rd0_par_err),
`endif
        .acc_ok_o  (rd0_ok),
        .pd_o      (rd0_pd)
    );

    predecode_port #(.GateAll(GATE_ALL)) u_rd1 (
        .clk_i     (clk),
        .rst_i     (reset),
        .en_i      (rd1_enable),
        .addr_i    (rd1_addr),
`ifdef PREDECODE_PARITY_EN
        .par_i     (rd1_addr_par),
        .err_clr_i (err_clr),
        .par_err_o (rd1_par_err),
`endif
        .acc_ok_o  (rd1_ok),
        .pd_o      (rd1_pd)
    );

    predecode_port #(.GateAll(GATE_ALL)) u_wr0 (
        .clk_i     (clk),
        .rst_i     (reset),
        .en_i      (wr0_enable),
        .addr_i    (wr0_addr),
`ifdef PREDECODE_PARITY_EN
        .par_i     (wr0_addr_par),
        .err_clr_i (err_clr),
        .par_err_o (wr0_par_err),
`endif
        .acc_ok_o  (wr0_ok),
        .pd_o      (wr0_pd)
    );

    assign {rd0_c_na0, rd0_c_a0, rd0_na1_na2, rd0_na1_a2, rd0_a1_na2, rd0_a1_a2,
            rd0_na3, rd0_a3, rd0_na4_na5, rd0_na4_a5, rd0_a4_na5, rd0_a4_a5} = rd0_pd;
    assign {rd1_c_na0, rd1_c_a0, rd1_na1_na2, rd1_na1_a2, rd1_a1_na2, rd1_a1_a2,
            rd1_na3, rd1_a3, rd1_na4_na5, rd1_na4_a5, rd1_a4_na5, rd1_a4_a5} = rd1_pd;
    assign {wr0_c_na0, wr0_c_a0, wr0_na1_na2, wr0_na1_a2, wr0_a1_na2, wr0_a1_a2,
            wr0_na3, wr0_a3, wr0_na4_na5, wr0_na4_a5, wr0_a4_na5, wr0_a4_a5} = wr0_pd;

    // Registered so the flags line up with the predecode outputs of the same access.
    logic rd0_hit_q, rd0_hit_d, rd1_hit_q, rd1_hit_d;

    always_comb begin
        rd0_hit_d = rd0_ok & wr0_ok & (rd0_addr == wr0_addr);
        rd1_hit_d = rd1_ok & wr0_ok & (rd1_addr == wr0_addr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd0_hit_q <= 1'b0;
            rd1_hit_q <= 1'b0;
        end else begin
            rd0_hit_q <= rd0_hit_d;
            rd1_hit_q <= rd1_hit_d;
        end
    end

    assign rd0_wr0_hit = rd0_hit_q;
    assign rd1_wr0_hit = rd1_hit_q;

endmodule

// File: tb/tb_wordline_predecode_64.sv
// Directed self-checking bench for wordline_predecode_64 (GATE_ALL=0).
// Parity steps are built only when PREDECODE_PARITY_EN is defined.
module tb_wordline_predecode_64;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd0_enable, rd1_enable, wr0_enable;
    logic [0:5] rd0_addr, rd1_addr, wr0_addr;
    logic rd0_c_na0, rd0_c_a0, rd0_na1_na2, rd0_na1_a2, rd0_a1_na2, rd0_a1_a2;
    logic rd0_na3, rd0_a3, rd0_na4_na5, rd0_na4_a5, rd0_a4_na5, rd0_a4_a5;
    logic rd1_c_na0, rd1_c_a0, rd1_na1_na2, rd1_na1_a2, rd1_a1_na2, rd1_a1_a2;
    logic rd1_na3, rd1_a3, rd1_na4_na5, rd1_na4_a5, rd1_a4_na5, rd1_a4_a5;
    logic wr0_c_na0, wr0_c_a0, wr0_na1_na2, wr0_na1_a2, wr0_a1_na2, wr0_a1_a2;
    logic wr0_na3, wr0_a3, wr0_na4_na5, wr0_na4_a5, wr0_a4_na5, wr0_a4_a5;
    logic rd0_wr0_hit, rd1_wr0_hit;
`ifdef PREDECODE_PARITY_EN
    logic rd0_addr_par, rd1_addr_par, wr0_addr_par, err_clr;
    logic rd0_par_err, rd1_par_err, wr0_par_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wordline_predecode_64 #(.GATE_ALL(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .rd0_enable  (rd0_enable),
        .rd1_enable  (rd1_enable),
        .wr0_enable  (wr0_enable),
        .rd0_addr    (rd0_addr),
        .rd1_addr    (rd1_addr),
        .wr0_addr    (wr0_addr),
`ifdef PREDECODE_PARITY_EN
        .rd0_addr_par(rd0_addr_par),
        .rd1_addr_par(rd1_addr_par),
        .wr0_addr_par(wr0_addr_par),
        .err_clr     (err_clr),
        .rd0_par_err (rd0_par_err),
        .rd1_par_err (rd1_par_err),
        .wr0_par_err (wr0_par_err),
`endif
        .rd0_c_na0   (rd0_c_na0),   .rd0_c_a0   (rd0_c_a0),
        .rd0_na1_na2 (rd0_na1_na2), .rd0_na1_a2 (rd0_na1_a2),
        .rd0_a1_na2  (rd0_a1_na2),  .rd0_a1_a2  (rd0_a1_a2),
        .rd0_na3     (rd0_na3),     .rd0_a3     (rd0_a3),
        .rd0_na4_na5 (rd0_na4_na5), .rd0_na4_a5 (rd0_na4_a5),
        .rd0_a4_na5  (rd0_a4_na5),  .rd0_a4_a5  (rd0_a4_a5),
        .rd1_c_na0   (rd1_c_na0),   .rd1_c_a0   (rd1_c_a0),
        .rd1_na1_na2 (rd1_na1_na2), .rd1_na1_a2 (rd1_na1_a2),
        .rd1_a1_na2  (rd1_a1_na2),  .rd1_a1_a2  (rd1_a1_a2),
        .rd1_na3     (rd1_na3),     .rd1_a3     (rd1_a3),
        .rd1_na4_na5 (rd1_na4_na5), .rd1_na4_a5 (rd1_na4_a5),
        .rd1_a4_na5  (rd1_a4_na5),  .rd1_a4_a5  (rd1_a4_a5),
        .wr0_c_na0   (wr0_c_na0),   .wr0_c_a0   (wr0_c_a0),
        .wr0_na1_na2 (wr0_na1_na2), .wr0_na1_a2 (wr0_na1_a2),
        .wr0_a1_na2  (wr0_a1_na2),  .wr0_a1_a2  (wr0_a1_a2),
        .wr0_na3     (wr0_na3),     .wr0_a3     (wr0_a3),
        .wr0_na4_na5 (wr0_na4_na5), .wr0_na4_a5 (wr0_na4_a5),
        .wr0_a4_na5  (wr0_a4_na5),  .wr0_a4_a5  (wr0_a4_a5),
        .rd0_wr0_hit (rd0_wr0_hit),
        .rd1_wr0_hit (rd1_wr0_hit)
    );

    // Bundles ordered c_na0 (bit 11) down to a4_a5 (bit 0).
    logic [11:0] rd0_b, rd1_b, wr0_b;
    assign rd0_b = {rd0_c_na0, rd0_c_a0, rd0_na1_na2, rd0_na1_a2, rd0_a1_na2, rd0_a1_a2,
                    rd0_na3, rd0_a3, rd0_na4_na5, rd0_na4_a5, rd0_a4_na5, rd0_a4_a5};
    assign rd1_b = {rd1_c_na0, rd1_c_a0, rd1_na1_na2, rd1_na1_a2, rd1_a1_na2, rd1_a1_a2,
                    rd1_na3, rd1_a3, rd1_na4_na5, rd1_na4_a5, rd1_a4_na5, rd1_a4_a5};
    assign wr0_b = {wr0_c_na0, wr0_c_a0, wr0_na1_na2, wr0_na1_a2, wr0_a1_na2, wr0_a1_a2,
                    wr0_na3, wr0_a3, wr0_na4_na5, wr0_na4_a5, wr0_a4_na5, wr0_a4_a5};

    localparam logic [11:0] IdleB = 12'h228;  // na1_na2, na3, na4_na5 high

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference: expected bundle for a valid access to address a.
    function automatic logic [11:0] model(input logic [0:5] a);
        logic [11:0] b;
        b = '0;
        b[11 - 0] = ~a[0];
        b[11 - 1] = a[0];
        b[11 - 2 - {30'd0, a[1:2]}] = 1'b1;
        b[11 - 6 - {31'd0, a[3]}] = 1'b1;
        b[11 - 8 - {30'd0, a[4:5]}] = 1'b1;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        rd0_enable = 1'b0; rd1_enable = 1'b0; wr0_enable = 1'b0;
        rd0_addr = '0; rd1_addr = '0; wr0_addr = '0;
`ifdef PREDECODE_PARITY_EN
        rd0_addr_par = 1'b0; rd1_addr_par = 1'b0; wr0_addr_par = 1'b0; err_clr = 1'b0;
`endif
        tick();
        tick();
        chk("reset_rd0", rd0_b, IdleB);
        chk("reset_rd1", rd1_b, IdleB);
        chk("reset_wr0", wr0_b, IdleB);
        chk("reset_hits", {10'd0, rd0_wr0_hit, rd1_wr0_hit}, 12'd0);
        reset = 1'b0;
        tick();
        chk("idle_rd0", rd0_b, IdleB);

        // rd0 at 101101 for one cycle
        rd0_enable = 1'b1; rd0_addr = 6'b101101;
        tick();
        chk("rd0_access", rd0_b, 12'h514);
        chk("rd1_untouched", rd1_b, IdleB);
        rd0_enable = 1'b0; rd0_addr = 6'b000000;
        tick();
        chk("rd0_after_idle", rd0_b, 12'h114);

        // rd1/wr0 collision at 37
        rd1_enable = 1'b1; rd1_addr = 6'd37;
        wr0_enable = 1'b1; wr0_addr = 6'd37;
        tick();
        chk("hit_37", {10'd0, rd0_wr0_hit, rd1_wr0_hit}, 12'b01);
        chk("rd1_37", rd1_b, model(6'd37));
        chk("wr0_37", wr0_b, model(6'd37));
        rd1_enable = 1'b0; wr0_enable = 1'b0;
        tick();
        chk("hit_one_cycle", {10'd0, rd0_wr0_hit, rd1_wr0_hit}, 12'b00);

        // Near miss 37 vs 38; rd0 and rd1 share an address, which is not a collision
        rd0_enable = 1'b1; rd0_addr = 6'd37;
        rd1_enable = 1'b1; rd1_addr = 6'd37;
        wr0_enable = 1'b1; wr0_addr = 6'd38;
        tick();
        chk("nohit_38", {10'd0, rd0_wr0_hit, rd1_wr0_hit}, 12'b00);
        chk("wr0_38", wr0_b, model(6'd38));
        // Same address on wr0 flags rd0 too
        wr0_addr = 6'd37;
        tick();
        chk("hit_both", {10'd0, rd0_wr0_hit, rd1_wr0_hit}, 12'b11);
        rd0_enable = 1'b0; rd1_enable = 1'b0; wr0_enable = 1'b0;
        tick();

        // Back-to-back sweep on wr0
        wr0_enable = 1'b1;
        for (int i = 0; i < 64; i++) begin
            wr0_addr = 6'(i);
            tick();
            chk($sformatf("sweep_%0d", i), wr0_b, model(6'(i)));
        end
        wr0_enable = 1'b0;
        tick();
        chk("sweep_end_hold", wr0_b, model(6'd63) & 12'h3ff);

        // Asynchronous reset right after an access edge
        rd0_enable = 1'b1; rd0_addr = 6'b101101;
        rd1_enable = 1'b1; rd1_addr = 6'd12;
        wr0_enable = 1'b1; wr0_addr = 6'd12;
        tick();
        chk("pre_reset_rd0", rd0_b, 12'h514);
        chk("pre_reset_hit", {10'd0, rd0_wr0_hit, rd1_wr0_hit}, 12'b01);
        reset = 1'b1;
        #1;
        chk("async_rd0", rd0_b, IdleB);
        chk("async_wr0", wr0_b, IdleB);
        chk("async_hits", {10'd0, rd0_wr0_hit, rd1_wr0_hit}, 12'b00);
        rd0_enable = 1'b0; rd1_enable = 1'b0; wr0_enable = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_rd1", rd1_b, IdleB);

`ifdef PREDECODE_PARITY_EN
        wr0_enable = 1'b1; wr0_addr = 6'd3; wr0_addr_par = 1'b1;
        tick();
        chk("par_c_lines", {10'd0, wr0_c_na0, wr0_c_a0}, 12'd0);
        chk("par_err_set", {11'd0, wr0_par_err}, 12'd1);
        wr0_enable = 1'b0; wr0_addr_par = 1'b0;
        tick();
        chk("par_err_sticky", {11'd0, wr0_par_err}, 12'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("par_err_clr", {11'd0, wr0_par_err}, 12'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wordline_predecode_64.md
Name: wordline_predecode_64

Overview:
- Registered address predecoder that drives the predecoded select lines consumed by the 64-wordline decoders.
- Serves three ports: rd0, rd1 and wr0.
- Per port it captures a binary 6-bit address plus enable and produces 12 predecode lines: center select (a0), 1:2 group, a3 group and 4:5 group.
- Also flags same-cycle rd/wr address collisions for the array shard control.

Parameters:
- GATE_ALL, 0: 0 gates only the c_* lines with valid; 1 gates every predecode group with valid (all lines low when idle).

Ports:
- clk  input  1  array clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- rd0_enable, rd1_enable, wr0_enable  input  1 each  port access request this cycle
- rd0_addr, rd1_addr, wr0_addr  input  [0:5] each  binary address; bit 0 = MSB
- <p>_c_na0, <p>_c_a0  output  1 each  center select, where <p> is rd0/rd1/wr0
- <p>_na1_na2, <p>_na1_a2, <p>_a1_na2, <p>_a1_a2  output  1 each  one-hot group for a1:a2
- <p>_na3, <p>_a3  output  1 each  one-hot group for a3
- <p>_na4_na5, <p>_na4_a5, <p>_a4_na5, <p>_a4_a5  output  1 each  one-hot group for a4:a5
- rd0_wr0_hit, rd1_wr0_hit  output  1 each  registered collision flag, aligned with the predecode outputs

Behaviour:
- Per port, state is a valid flop v and a 6-bit address register A.
- Each edge: v <= enable. A loads addr only when enable=1; otherwise A holds, so the idle groups do not toggle.
- Latency: enable/addr sampled at edge N; predecode lines valid after edge N, for exactly one cycle per enable cycle.
- Back-to-back enables give back-to-back accesses with no bubble.
- c_na0 = v & ~A[0]; c_a0 = v & A[0].
- The remaining groups are decoded purely from A[1:2], A[3] and A[4:5]. Each group is exactly one-hot.
- With GATE_ALL=1, every group is ANDed with v and is all-zero when v=0.
- At most one of c_na0/c_a0 is high; both are low when v=0. The downstream decoder therefore fires at most one wordline per port.
- Reset (async assert, any time including mid-access): v=0 and A=0.
  - GATE_ALL=0 outputs: all c_* = 0; na1_na2 = 1, na3 = 1, na4_na5 = 1; all other lines 0.
  - GATE_ALL=1 outputs: all lines 0.
  - Hit flags = 0.
- Reset deassertion is synchronous to clk by the caller. The first access needs enable on the first edge after release.
- Collision: rdX_wr0_hit <= rdX_enable & wr0_enable & (rdX_addr == wr0_addr). It is registered, so it is valid in the same cycle as the predecode lines.
- rd0 and rd1 at the same address is legal and not flagged.
- Hit only flags the collision; it never blocks a port. Read data on a hit is owned by the shard control.
- No state machine beyond the per-port valid; no handshake backpressure, since the decoder always accepts.

Optional Feature:
- Macro PREDECODE_PARITY_EN.
- When defined, these ports are added:
  - rd0_addr_par, rd1_addr_par, wr0_addr_par: input 1 each, even parity over addr[0:5] plus par.
  - err_clr: input 1.
  - rd0_par_err, rd1_par_err, wr0_par_err: output 1 each.
- Parity is checked only when enable=1.
- On mismatch, that port's v is forced to 0 for that access, so no wordline fires, and its sticky err bit sets.
- Err bits clear on err_clr and reset to 0. Set wins over a simultaneous err_clr.
- The hit flag is also suppressed for an errored port.
- When not defined: none of these ports exist and no parity logic is present.

Decomposition:
- Package wordline_predecode_pkg holds:
  - WL_ADDR_W = 6
  - the group-width constants (2, 4, 2, 4)
  - a typedef struct for the 12-bit predecode bundle, in field order c_na0 … a4_a5
- Natural sub-module: predecode_port.
  - It contains v, A, the decode logic and the optional parity check.
  - It is instantiated three times; the top adds the two comparators and the hit flops.

Test Plan:
- Reset, then idle: all c_* = 0 and na1_na2 = na3 = na4_na5 = 1 (GATE_ALL=0); hit flags 0.
- rd0 enable=1, addr=6'b101101 at edge N, enable=0 at N+1.
  - After N: c_a0 = 1, na1_a2 = 1, a3 = 1, na4_a5 = 1.
  - After N+1: c_* = 0 and the other groups hold.
- rd1 and wr0 both addr=6'd37, enabled together: rd1_wr0_hit = 1 for one cycle.
- Same stimulus with wr0 addr=6'd38: hit = 0.
- Sweep all 64 addresses back-to-back on wr0.
  - Each cycle exactly one c line and exactly one line per group is high.
  - Composite decode equals the address with no gaps.
- Assert reset mid-access, right after an enable edge: outputs go to reset values immediately with no clock.
- With PREDECODE_PARITY_EN: wr0 addr=6'd3 with par=1 (bad) → wr0 c lines stay 0 and wr0_par_err = 1 and stays sticky. Pulsing err_clr → 0.
